mips_mc_ctrl: RTL and testbench

- Multicycle control FSM for the simple MIPS core; it sequences the shared PC/IR/regfile/ALU/memory datapath one state per advance.
- Decodes opcode/funct into per-state control strobes and the ALU control code, resolves beq from the ALU zero flag, and exposes its state number on `timer` for board display.
- Sits between the instruction register and the datapath muxes, inside the mipscpu top.

---
 rtl/mips_mc_pkg.sv | 77 +++++++
 rtl/mips_alu_dec.sv | 29 ++
 rtl/mips_mc_ctrl.sv | 154 +++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package mips_mc_pkg;

  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALU_CTL_W = 3;
  localparam int unsigned STATE_W   = 4;

  // Encodings double as the timer display code.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 3'b111;

  // ALU operation class requested by the FSM; FUNCT defers to the R-type field.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  // Per-state Moore control word, before adv gating and branch resolution.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_write: 1'b0, branch: 1'b0, pc_src: 2'd0, i_or_d: 1'b0,
    mem_read: 1'b0, mem_write: 1'b0, ir_write: 1'b0, reg_dst: 1'b0,
    mem_to_reg: 1'b0, reg_write: 1'b0, alu_src_a: 1'b0, alu_src_b: 2'd0,
    alu_op: ALUOP_ADD, halted: 1'b0
  };

endpackage

// File: rtl/mips_alu_dec.sv
// ALU control decoder: (alu_op class, funct) -> 3-bit ALU function code.
module mips_alu_dec
  import mips_mc_pkg::*;
(
  input  alu_op_t              alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALU_CTL_W-1:0] alu_ctl
);

  // Unknown funct codes fall back to add so R-type write-back still completes.
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with Moore strobes and state display on timer.
// Optional SINGLE_STEP_EN: advance one state per rising edge of key_ok.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_ok,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 alu_zero_flag,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [STATE_W-1:0]   timer,
  output logic                 halted
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   adv;

`ifdef SINGLE_STEP_EN
  // Resets high so a key already held at reset release does not count as a press.
  logic key_q;

  always_ff @(posedge clk) begin
    if (rst) key_q <= 1'b1;
    else     key_q <= key_ok;
  end

  assign adv = key_ok & ~key_q;
`else
  logic unused_key_ok;
  assign unused_key_ok = key_ok;
  assign adv = 1'b1;
`endif

  // State register; reset wins over an advance.
  always_ff @(posedge clk) begin
    if (rst)      state_q <= S_FETCH;
    else if (adv) state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                      state_d = S_R_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
        else if (opcode == OP_J)                     state_d = S_JUMP;
        else if (opcode == OP_ADDI)                  state_d = S_I_EXEC;
        else if (ILLEGAL_HALT)                       state_d = S_HALT;
        else                                         state_d = S_FETCH;
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore control word per state.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'd1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = 2'd0;
      end
      S_DECODE: ctrl.alu_src_b = 2'd3;
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = 2'd1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'd2;
      end
      S_I_WB:  ctrl.reg_write = 1'b1;
      S_HALT:  ctrl.halted    = 1'b1;
      default: ctrl = CTRL_IDLE;
    endcase
  end

  mips_alu_dec u_alu_dec (
    .alu_op  (ctrl.alu_op),
    .funct   (funct),
    .alu_ctl (alu_ctl)
  );

  // Write strobes commit only on an advance cycle; selects and mem_read do not.
  assign pc_en      = (ctrl.pc_write | (ctrl.branch & alu_zero_flag)) & adv;
  assign ir_write   = ctrl.ir_write & adv;
  assign mem_write  = ctrl.mem_write & adv;
  assign reg_write  = ctrl.reg_write & adv;
  assign pc_src     = ctrl.pc_src;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign halted     = ctrl.halted;
  assign timer      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl; a second instance runs with ILLEGAL_HALT = 0.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst, key_ok, alu_zero_flag;
  logic [5:0] opcode, funct;

  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctl;
  logic [3:0] timer;

  logic       nh_pc_en, nh_i_or_d, nh_mem_read, nh_mem_write, nh_ir_write, nh_reg_dst, nh_mem_to_reg;
  logic       nh_reg_write, nh_alu_src_a, nh_halted;
  logic [1:0] nh_pc_src, nh_alu_src_b;
  logic [2:0] nh_alu_ctl;
  logic [3:0] nh_timer;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .key_ok(key_ok), .opcode(opcode), .funct(funct),
    .alu_zero_flag(alu_zero_flag), .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .timer(timer), .halted(halted)
  );

  mips_mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .key_ok(key_ok), .opcode(opcode), .funct(funct),
    .alu_zero_flag(alu_zero_flag), .pc_en(nh_pc_en), .pc_src(nh_pc_src), .i_or_d(nh_i_or_d),
    .mem_read(nh_mem_read), .mem_write(nh_mem_write), .ir_write(nh_ir_write),
    .reg_dst(nh_reg_dst), .mem_to_reg(nh_mem_to_reg), .reg_write(nh_reg_write),
    .alu_src_a(nh_alu_src_a), .alu_src_b(nh_alu_src_b), .alu_ctl(nh_alu_ctl),
    .timer(nh_timer), .halted(nh_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_fetch_wr;
`ifdef SINGLE_STEP_EN
    exp_fetch_wr = 1'b0;
`else
    exp_fetch_wr = 1'b1;
`endif
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (timer !== 4'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: timer=%0d halted=%b, want timer=0 halted=0", timer, halted);
    end
    n_cmp++;
    if ({mem_read, ir_write, pc_en, alu_src_b, alu_ctl, pc_src} !== {1'b1, exp_fetch_wr, exp_fetch_wr, 2'd1, 3'b010, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_fetch_strobes: mr=%b irw=%b pc_en=%b srcb=%0d alu=%b pcsrc=%0d", mem_read, ir_write, pc_en, alu_src_b, alu_ctl, pc_src);
    end
    n_cmp++;
    if ({mem_write, reg_write, i_or_d, alu_src_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle_strobes: mw=%b rw=%b iord=%b srca=%b, want 0000", mem_write, reg_write, i_or_d, alu_src_a);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    opcode = 6'h23;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (timer !== exp_st[i]) begin
        n_fail++;
        $display("FAIL lw_timer[%0d]: got %0d want %0d", i, timer, exp_st[i]);
      end
      n_cmp++;
      if (reg_write !== (exp_st[i] == 4'd4) || mem_to_reg !== (exp_st[i] == 4'd4) || pc_en !== (exp_st[i] == 4'd0)) begin
        n_fail++;
        $display("FAIL lw_strobes[%0d]: rw=%b m2r=%b pc_en=%b in state %0d", i, reg_write, mem_to_reg, pc_en, exp_st[i]);
      end
      if (exp_st[i] == 4'd3) begin
        n_cmp++;
        if (mem_read !== 1'b1 || i_or_d !== 1'b1) begin
          n_fail++;
          $display("FAIL lw_memrd: mem_read=%b i_or_d=%b want 1 1", mem_read, i_or_d);
        end
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    opcode = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (timer !== exp_st[i] || mem_write !== (exp_st[i] == 4'd5) || reg_write !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_step[%0d]: timer=%0d mw=%b rw=%b want state %0d", i, timer, mem_write, reg_write, exp_st[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [2] = '{6'h22, 6'h3F};
    logic [2:0] alu [2] = '{3'b110, 3'b010};
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 6'h00;
    for (int k = 0; k < 2; k++) begin
      funct = fn[k];
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (timer !== exp_st[i]) begin
          n_fail++;
          $display("FAIL rtype_timer[%0d,%0d]: got %0d want %0d", k, i, timer, exp_st[i]);
        end
        if (exp_st[i] == 4'd6) begin
          n_cmp++;
          if (alu_ctl !== alu[k] || alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin
            n_fail++;
            $display("FAIL rtype_exec[%0d]: alu=%b srca=%b srcb=%0d want alu=%b 1 0", k, alu_ctl, alu_src_a, alu_src_b, alu[k]);
          end
        end
        if (exp_st[i] == 4'd7) begin
          n_cmp++;
          if (reg_dst !== 1'b1 || reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rtype_wb[%0d]: reg_dst=%b reg_write=%b want 1 1", k, reg_dst, reg_write);
          end
        end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    opcode = 6'h04;
    for (int k = 0; k < 2; k++) begin
      alu_zero_flag = (k == 0);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (timer !== exp_st[i]) begin
          n_fail++;
          $display("FAIL beq_timer[%0d,%0d]: got %0d want %0d", k, i, timer, exp_st[i]);
        end
        if (exp_st[i] == 4'd8) begin
          n_cmp++;
          if (pc_en !== alu_zero_flag || pc_src !== 2'd1 || alu_ctl !== 3'b110) begin
            n_fail++;
            $display("FAIL beq_resolve[z=%b]: pc_en=%b pc_src=%0d alu=%b", alu_zero_flag, pc_en, pc_src, alu_ctl);
          end
        end
        if (exp_st[i] == 4'd1) begin
          n_cmp++;
          if (pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_decode_pc_en: got %b want 0", pc_en);
          end
        end
        if (i < 3) tick();
      end
    end
    alu_zero_flag = 1'b0;
  endtask

  task automatic test_jump_addi();
    logic [3:0] j_st [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    logic [3:0] a_st [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    opcode = 6'h02;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (timer !== j_st[i] || (j_st[i] == 4'd9 && (pc_en !== 1'b1 || pc_src !== 2'd2))) begin
        n_fail++;
        $display("FAIL j_step[%0d]: timer=%0d pc_en=%b pc_src=%0d want state %0d", i, timer, pc_en, pc_src, j_st[i]);
      end
      if (i < 3) tick();
    end
    opcode = 6'h08;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (timer !== a_st[i] || reg_write !== (a_st[i] == 4'd11) ||
          (a_st[i] == 4'd10 && alu_src_b !== 2'd2) || (a_st[i] == 4'd11 && reg_dst !== 1'b0)) begin
        n_fail++;
        $display("FAIL addi_step[%0d]: timer=%0d rw=%b srcb=%0d rdst=%b want state %0d", i, timer, reg_write, alu_src_b, reg_dst, a_st[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_illegal();
    opcode = 6'h3F;
    tick();
    tick();
    n_cmp++;
    if (timer !== 4'd15 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_entry: timer=%0d halted=%b want 15 1", timer, halted);
    end
    n_cmp++;
    if (nh_timer !== 4'd0 || nh_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL nohalt_return: timer=%0d halted=%b want 0 0", nh_timer, nh_halted);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (timer !== 4'd15 || halted !== 1'b1 || mem_read !== 1'b0 || pc_en !== 1'b0 || reg_write !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_sticky[%0d]: timer=%0d halted=%b mr=%b pc_en=%b rw=%b", c, timer, halted, mem_read, pc_en, reg_write);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (timer !== 4'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_rst_exit: timer=%0d halted=%b want 0 0", timer, halted);
    end
  endtask

  task automatic test_rst_mid();
    opcode = 6'h23;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (timer !== 4'd3) begin
      n_fail++;
      $display("FAIL rstmid_reach: timer=%0d want 3", timer);
    end
    rst = 1'b1;
    n_cmp++;
    if (mem_write !== 1'b0 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_wr_before: mw=%b rw=%b want 0 0", mem_write, reg_write);
    end
    tick();
    n_cmp++;
    if (timer !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_to_fetch: timer=%0d mw=%b rw=%b want 0 0 0", timer, mem_write, reg_write);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_step();
    logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    int rw_pulses = 0;
    int pc_pulses = 0;
    opcode = 6'h23;
    rst = 1'b1;
    key_ok = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    n_cmp++;
    if (timer !== 4'd0) begin
      n_fail++;
      $display("FAIL step_held_at_reset: timer=%0d want 0", timer);
    end
    key_ok = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    for (int p = 0; p < 5; p++) begin
      key_ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (c == 10) key_ok = 1'b0;
        @(negedge clk);
        if (reg_write === 1'b1) rw_pulses++;
        if (pc_en === 1'b1) pc_pulses++;
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if (timer !== exp_st[p]) begin
        n_fail++;
        $display("FAIL step_press[%0d]: timer=%0d want %0d", p, timer, exp_st[p]);
      end
    end
    n_cmp++;
    if (rw_pulses != 1 || pc_pulses != 1) begin
      n_fail++;
      $display("FAIL step_pulses: reg_write cycles=%0d pc_en cycles=%0d want 1 1", rw_pulses, pc_pulses);
    end
  endtask

  initial begin
    rst = 1'b1;
    key_ok = 1'b0;
    opcode = 6'h00;
    funct = 6'h20;
    alu_zero_flag = 1'b0;
    test_reset();
`ifdef SINGLE_STEP_EN
    test_single_step();
`else
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_jump_addi();
    test_illegal();
    test_rst_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
